sum_deskew_collector: RTL

Drains the bottom edge of the systolic matrix-multiply array. Each column's final partial sums leave the bottom-row PEs skewed by one cycle per column. This block delays every column so that one result row lines up across all columns, buffers aligned rows in a FIFO, and presents them downstream on a valid/ready interface. It is the output-side counterpart of the left-edge activation feeder. It also flags skew faults, flags overflow, and marks tile boundaries.

---
 rtl/systolic_pkg.sv | 12 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/sum_deskew_collector.sv | 117 +++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and row typedef for the systolic matrix-multiply array and its
// edge feeders/collectors.
package systolic_pkg;

   localparam int DEFAULT_N            = 4;
   localparam int DEFAULT_DATA_WIDTH   = 8;
   localparam int DEFAULT_RESULT_WIDTH = 32;

   // One packed result row, column j at bits [j*RESULT_WIDTH +: RESULT_WIDTH].
   typedef logic [DEFAULT_N*DEFAULT_RESULT_WIDTH-1:0] row_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/count status.
// A write while full is accepted only when a read happens in the same cycle.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             wr_fire;
   logic             rd_fire;

   always_comb begin
      full    = (count_q == CW'(DEPTH));
      empty   = (count_q == '0);
      wr_fire = wr_en && (!full || rd_en);
      rd_fire = rd_en && !empty;
      rd_data = mem[rd_ptr];
      count   = count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
         if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_fire, rd_fire})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/sum_deskew_collector.sv
// Bottom-edge collector of the systolic array: deskews per-column sums into
// aligned rows, buffers them and hands them downstream with tile markers.
module sum_deskew_collector
   import systolic_pkg::*;
#(
   parameter int N            = DEFAULT_N,
   parameter int RESULT_WIDTH = DEFAULT_RESULT_WIDTH,
   parameter int DEPTH        = 16,
   parameter int SLACK        = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N-1:0]              col_valid,
   input  logic [N*RESULT_WIDTH-1:0] col_sum,
   input  logic [15:0]               tile_rows,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N*RESULT_WIDTH-1:0] out_data,
   output logic                      out_last,
   output logic                      tile_done,
   output logic                      space_avail,
   output logic                      overflow,
   output logic                      skew_err
);

   localparam int RW    = RESULT_WIDTH;
   localparam int ROW_W = N * RW;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic [N-1:0]     aligned_valid;
   logic [ROW_W-1:0] aligned_sum;

   // Column j lags column 0 by j cycles, so it needs N-1-j stages to catch up.
   for (genvar j = 0; j < N; j++) begin : g_col
      localparam int D = N - 1 - j;
      if (D == 0) begin : g_pass
         assign aligned_valid[j]         = col_valid[j];
         assign aligned_sum[j*RW +: RW]  = col_sum[j*RW +: RW];
      end else begin : g_dly
         logic [D-1:0]  v_sr;
         logic [RW-1:0] s_sr [D];
         always_ff @(posedge clk) begin
            if (reset) begin
               v_sr <= '0;
            end else begin
               v_sr[0] <= col_valid[j];
               for (int k = 1; k < D; k++) v_sr[k] <= v_sr[k-1];
            end
         end
         always_ff @(posedge clk) begin
            s_sr[0] <= col_sum[j*RW +: RW];
            for (int k = 1; k < D; k++) s_sr[k] <= s_sr[k-1];
         end
         assign aligned_valid[j]        = v_sr[D-1];
         assign aligned_sum[j*RW +: RW] = s_sr[D-1];
      end
   end

   logic [ROW_W:0]  fifo_head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   count_next;
   logic [15:0]     row_cnt;
   logic            row_full;
   logic            row_partial;
   logic            row_last;
   logic            push;
   logic            pop;
   logic            drop;

   // Downstream handshake: out_valid/out_data/out_last hold steady until the
   // cycle where out_valid & out_ready are both high; that edge pops the head.
   always_comb begin
      row_full    = &aligned_valid;
      row_partial = (|aligned_valid) && !row_full;
      row_last    = (tile_rows == 16'd0) || (row_cnt == tile_rows - 16'd1);
      pop         = !fifo_empty && out_ready;
      push        = row_full && (!fifo_full || pop);
      drop        = row_full && fifo_full && !pop;
      count_next  = fifo_count + CW'(push) - CW'(pop);
      out_valid   = !fifo_empty;
      out_last    = fifo_empty ? 1'b0 : fifo_head[ROW_W];
      out_data    = fifo_empty ? '0 : fifo_head[ROW_W-1:0];
      tile_done   = pop && fifo_head[ROW_W];
   end

   sync_fifo #(
      .WIDTH (ROW_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .wr_data ({row_last, aligned_sum}),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         row_cnt     <= '0;
         overflow    <= 1'b0;
         skew_err    <= 1'b0;
         space_avail <= 1'b1;
      end else begin
         if (push) row_cnt <= row_last ? 16'd0 : row_cnt + 16'd1;
         if (drop) overflow <= 1'b1;
         if (row_partial) skew_err <= 1'b1;
         space_avail <= (int'(count_next) + SLACK) <= DEPTH;
      end
   end

endmodule
